matrix_operand_loader: RTL and testbench

MATRIX_OPERAND_LOADER -- requirements
Module: matrix_operand_loader

---
 rtl/mm_pkg.sv | 9 +
 rtl/operand_bank.sv | 38 +++
 rtl/matrix_operand_loader.sv | 104 ++++++++++
 tb/tb_matrix_operand_loader.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply operand path: default operand
// geometry plus the bank-select and row-counter types used by the loader.
package mm_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_N          = 4;

  typedef logic                       bank_idx_t;
  typedef logic [$clog2(DEF_N)-1:0]   row_cnt_t;
endpackage

// File: rtl/operand_bank.sv
// One operand bank: NxN A and NxN B storage, written a row at a time and read
// as column k of A together with row k of B.
module operand_bank
  import mm_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N          = DEF_N
) (
  input  logic                           clk,
  input  logic                           wr_en,
  input  row_cnt_t                       wr_row,
  input  logic [N-1:0][DATA_WIDTH-1:0]   wr_a_row,
  input  logic [N-1:0][DATA_WIDTH-1:0]   wr_b_row,
  input  row_cnt_t                       rd_k,
  output logic [N-1:0][DATA_WIDTH-1:0]   a_col,
  output logic [N-1:0][DATA_WIDTH-1:0]   b_row
);

  logic [N-1:0][DATA_WIDTH-1:0] a_mem [N];
  logic [N-1:0][DATA_WIDTH-1:0] b_mem [N];

  // Storage is data only; it carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      a_mem[wr_row] <= wr_a_row;
      b_mem[wr_row] <= wr_b_row;
    end
  end

  always_comb begin
    a_col = '0;
    for (int i = 0; i < N; i++) begin
      a_col[i] = a_mem[i][rd_k];
    end
    b_row = b_mem[rd_k];
  end

endmodule

// File: rtl/matrix_operand_loader.sv
// Double-buffered operand loader: accepts A/B row pairs into one bank while the
// other bank streams column-of-A / row-of-B beats into the systolic array.
module matrix_operand_loader
  import mm_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N          = DEF_N
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [N-1:0][DATA_WIDTH-1:0]   in_a_row,
  input  logic [N-1:0][DATA_WIDTH-1:0]   in_b_row,
  input  logic                           sink_ready,
  output logic                           out_valid,
  output logic [N-1:0][DATA_WIDTH-1:0]   a_data,
  output logic [N-1:0][DATA_WIDTH-1:0]   b_data,
  output logic                           out_last
);

  localparam row_cnt_t LAST_ROW = row_cnt_t'(N - 1);

  logic [1:0]   full;
  bank_idx_t    wr_bank;
  bank_idx_t    rd_bank;
  row_cnt_t     wr_cnt;
  row_cnt_t     rd_cnt;
  logic         running;
  logic         accept;
  logic         drain;

  logic [N-1:0][DATA_WIDTH-1:0] bank_a [2];
  logic [N-1:0][DATA_WIDTH-1:0] bank_b [2];

  // running holds in_ready low through the reset edge and releases it on the
  // first edge that sees reset deasserted.
  assign in_ready  = running && !full[wr_bank];
  assign out_valid = full[rd_bank];
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && sink_ready;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    operand_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .N          (N)
    ) u_bank (
      .clk      (clk),
      .wr_en    (accept && (wr_bank == bank_idx_t'(b))),
      .wr_row   (wr_cnt),
      .wr_a_row (in_a_row),
      .wr_b_row (in_b_row),
      .rd_k     (rd_cnt),
      .a_col    (bank_a[b]),
      .b_row    (bank_b[b])
    );
  end

  always_comb begin
    a_data   = '0;
    b_data   = '0;
    out_last = 1'b0;
    if (out_valid) begin
      a_data   = bank_a[rd_bank];
      b_data   = bank_b[rd_bank];
      out_last = (rd_cnt == LAST_ROW);
    end
  end

  // Fill and drain always target different banks (the write bank is never full
  // while being filled, the read bank is always full while draining), so both
  // completions may land on the same edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      full    <= 2'b00;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      running <= 1'b0;
    end else begin
      running <= 1'b1;
      if (accept) begin
        if (wr_cnt == LAST_ROW) begin
          full[wr_bank] <= 1'b1;
          wr_cnt        <= '0;
          wr_bank       <= ~wr_bank;
        end else begin
          wr_cnt <= wr_cnt + row_cnt_t'(1);
        end
      end
      if (drain) begin
        if (rd_cnt == LAST_ROW) begin
          full[rd_bank] <= 1'b0;
          rd_cnt        <= '0;
          rd_bank       <= ~rd_bank;
        end else begin
          rd_cnt <= rd_cnt + row_cnt_t'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Directed bench for matrix_operand_loader with N = 4, 8-bit elements.
module tb_matrix_operand_loader;

  localparam int DW = 8;
  localparam int NN = 4;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [NN-1:0][DW-1:0]  in_a_row = '0;
  logic [NN-1:0][DW-1:0]  in_b_row = '0;
  logic                   sink_ready = 1'b0;
  logic                   out_valid;
  logic [NN-1:0][DW-1:0]  a_data;
  logic [NN-1:0][DW-1:0]  b_data;
  logic                   out_last;

  int n_checks = 0;
  int n_errors = 0;
  int mat_base = 0;

  logic [31:0] sl_a [4] = '{32'h0D090501, 32'h0E0A0602, 32'h0F0B0703, 32'h100C0804};
  logic [31:0] sl_b [4] = '{32'h00000001, 32'h00000100, 32'h00010000, 32'h01000000};

  matrix_operand_loader #(.DATA_WIDTH(DW), .N(NN)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a_row   (in_a_row),
    .in_b_row   (in_b_row),
    .sink_ready (sink_ready),
    .out_valid  (out_valid),
    .a_data     (a_data),
    .b_data     (b_data),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [7:0] a_el(input int m, input int r, input int c);
    return 8'((m * 16 + r * 4 + c + 1) & 255);
  endfunction

  function automatic logic [7:0] b_el(input int m, input int r, input int c);
    return 8'((128 + m * 16 + r * 5 + c * 3) & 255);
  endfunction

  // mode 0: sink always ready; mode 1: sink alternates 1,0; mode 2: sink held
  // off until both banks are full and 0xFF rows have been offered for 4 cycles.
  task automatic run(input int nmat, input int mode, input int budget);
    int loaded = 0;
    int row = 0;
    int cyc = 0;
    int hold = 0;
    int popped = 0;
    bit seen = 1'b0;
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic        ql[$];
    logic [NN-1:0][DW-1:0] ta;
    logic [NN-1:0][DW-1:0] tb;
    while ((loaded < nmat || qa.size() > 0) && cyc < budget) begin
      if (mode == 0) sink_ready = 1'b1;
      else if (mode == 1) sink_ready = (cyc % 2 == 0);
      else sink_ready = (loaded == nmat && hold >= 4);

      if (loaded < nmat) begin
        in_valid = 1'b1;
        for (int c = 0; c < NN; c++) begin
          in_a_row[c] = a_el(mat_base + loaded, row, c);
          in_b_row[c] = b_el(mat_base + loaded, row, c);
        end
      end else if (mode == 2 && hold < 4) begin
        in_valid = 1'b1;
        in_a_row = '1;
        in_b_row = '1;
        check_eq("full_in_ready", 64'(in_ready), 64'(0));
        hold++;
      end else begin
        in_valid = 1'b0;
      end

      if (out_valid) begin
        seen = 1'b1;
        if (qa.size() == 0) begin
          check_eq("spurious_valid", 64'(out_valid), 64'(0));
        end else begin
          check_eq("beat_a", 64'(a_data), 64'(qa[0]));
          check_eq("beat_b", 64'(b_data), 64'(qb[0]));
          check_eq("beat_last", 64'(out_last), 64'(ql[0]));
          if (sink_ready) begin
            void'(qa.pop_front());
            void'(qb.pop_front());
            void'(ql.pop_front());
            popped++;
          end
        end
      end else begin
        check_eq("idle_a_zero", 64'(a_data), 64'(0));
        if (mode == 0 && seen && popped < nmat * 4)
          check_eq("stream_valid", 64'(out_valid), 64'(1));
      end
      if (mode == 0 && loaded < nmat)
        check_eq("stream_in_ready", 64'(in_ready), 64'(1));

      if (in_valid && in_ready && loaded < nmat) begin
        row++;
        if (row == NN) begin
          for (int k = 0; k < NN; k++) begin
            for (int i = 0; i < NN; i++) begin
              ta[i] = a_el(mat_base + loaded, i, k);
              tb[i] = b_el(mat_base + loaded, k, i);
            end
            qa.push_back(32'(ta));
            qb.push_back(32'(tb));
            ql.push_back(k == NN - 1);
          end
          row = 0;
          loaded++;
        end
      end
      step();
      cyc++;
    end
    in_valid   = 1'b0;
    sink_ready = 1'b0;
    check_eq("run_in_budget", 64'(cyc < budget), 64'(1));
    check_eq("run_beats", 64'(popped), 64'(nmat * 4));
    mat_base += nmat;
  endtask

  initial begin
    // Reset held for three edges
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("rst_in_ready", 64'(in_ready), 64'(0));
      check_eq("rst_out_valid", 64'(out_valid), 64'(0));
      check_eq("rst_a_data", 64'(a_data), 64'(0));
      check_eq("rst_out_last", 64'(out_last), 64'(0));
    end
    reset = 1'b1;
    step();
    check_eq("rel_in_ready", 64'(in_ready), 64'(1));
    check_eq("rel_out_valid", 64'(out_valid), 64'(0));

    // Single load: A = 1..16, B = identity
    sink_ready = 1'b1;
    for (int r = 0; r < NN; r++) begin
      in_valid = 1'b1;
      for (int j = 0; j < NN; j++) begin
        in_a_row[j] = 8'(4 * r + j + 1);
        in_b_row[j] = (j == r) ? 8'd1 : 8'd0;
      end
      check_eq("sl_in_ready", 64'(in_ready), 64'(1));
      check_eq("sl_early_valid", 64'(out_valid), 64'(0));
      step();
    end
    in_valid = 1'b0;
    for (int k = 0; k < NN; k++) begin
      check_eq("sl_valid", 64'(out_valid), 64'(1));
      check_eq("sl_a", 64'(a_data), 64'(sl_a[k]));
      check_eq("sl_b", 64'(b_data), 64'(sl_b[k]));
      check_eq("sl_last", 64'(out_last), 64'(k == NN - 1));
      step();
    end
    check_eq("sl_done_valid", 64'(out_valid), 64'(0));
    check_eq("sl_done_a", 64'(a_data), 64'(0));
    check_eq("sl_done_b", 64'(b_data), 64'(0));

    // Streaming, backpressure, both banks full
    run(3, 0, 100);
    run(2, 1, 100);
    run(2, 2, 100);

    // Reset after beat 1 of a matrix while a second one is half loaded
    sink_ready = 1'b1;
    for (int r = 0; r < NN; r++) begin
      in_valid = 1'b1;
      for (int j = 0; j < NN; j++) begin
        in_a_row[j] = 8'h55;
        in_b_row[j] = 8'hAA;
      end
      step();
    end
    for (int k = 0; k < 2; k++) begin
      check_eq("mid_valid", 64'(out_valid), 64'(1));
      step();
    end
    in_valid = 1'b0;
    reset = 1'b0;
    step();
    check_eq("mid_rst_valid", 64'(out_valid), 64'(0));
    check_eq("mid_rst_in_ready", 64'(in_ready), 64'(0));
    check_eq("mid_rst_last", 64'(out_last), 64'(0));
    reset = 1'b1;
    step();
    check_eq("mid_rel_in_ready", 64'(in_ready), 64'(1));
    check_eq("mid_rel_valid", 64'(out_valid), 64'(0));
    run(1, 0, 50);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
